// File: rtl/mem_arbiter.sv
// Arbitrates the shared main memory between the I-cache fill path and the D-cache fill/write path.
// It runs one 8-word block fill or one single-word write at a time and steers the returned words back.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_done,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_valid,
  output logic [2:0]        fill_idx,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
);
  localparam logic [2:0] LAST = 3'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RECOVER} state_t;

  state_t            state_q, state_d;
  logic              side_q, side_d;       // 1 = D side owns the transaction
  logic              last_d_q, last_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        issue_q, issue_d;
  logic [2:0]        ret_q, ret_d;
  logic              iss_done_q, iss_done_d;
  logic              done;
  logic              busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      side_q     <= 1'b0;
      last_d_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      issue_q    <= '0;
      ret_q      <= '0;
      iss_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      side_q     <= side_d;
      last_d_q   <= last_d_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      issue_q    <= issue_d;
      ret_q      <= ret_d;
      iss_done_q <= iss_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    side_d     = side_q;
    last_d_d   = last_d_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    issue_d    = issue_q;
    ret_d      = ret_q;
    iss_done_d = iss_done_q;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_valid = 1'b0;
    fill_idx   = '0;
    fill_data  = '0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        issue_d    = '0;
        ret_d      = '0;
        iss_done_d = 1'b0;
        // D has priority unless it won the previous acceptance
        if (d_req && (!i_req || !last_d_q)) begin
          side_d   = 1'b1;
          last_d_d = 1'b1;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          state_d  = d_we ? WRITE : FILL;
        end else if (i_req) begin
          side_d   = 1'b0;
          last_d_d = 1'b0;
          addr_d   = i_addr;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (!iss_done_q) begin
          mem_en   = 1'b1;
          mem_addr = {addr_q[ADDR_W-1:4], issue_q, 1'b0};
          if (issue_q == LAST) iss_done_d = 1'b1;
          else                 issue_d    = issue_q + 3'd1;
        end
        // Only count returns for reads this fill actually issued
        if (mem_valid && (iss_done_q || (ret_q < issue_q))) begin
          fill_valid = 1'b1;
          fill_idx   = ret_q;
          fill_data  = mem_rdata;
          if (ret_q == LAST) begin
            ret_d   = '0;
            done    = 1'b1;
            state_d = RECOVER;
          end else begin
            ret_d = ret_q + 3'd1;
          end
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        done      = 1'b1;
        state_d   = RECOVER;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == FILL) || (state_q == WRITE);
  assign i_grant = busy & ~side_q;
  assign d_grant = busy &  side_q;
  assign i_done  = done & ~side_q;
  assign d_done  = done &  side_q;
endmodule
